// File: rtl/dcache_stage.sv
// Data-cache pipeline stage: 16-line direct-mapped, write-through, no-write-allocate
// cache between execute and writeback, with a blocking memory port.
module dcache_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        icache_stall,
  input  logic [31:0] ac_pc,
  input  logic [4:0]  ac_write_sel,
  input  logic        ac_is_load,
  input  logic        ac_is_store,
  input  logic        ac_is_wb,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ac_data2,
  output logic        dcache_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] cw_pc,
  output logic        cw_is_wb,
  output logic [4:0]  cw_write_sel,
  output logic [31:0] cw_result
);

  typedef enum logic [1:0] {IDLE, LOAD_MISS, STORE_WR, HOLD} state_t;

  state_t      state;
  logic [15:0] valid;
  logic [25:0] tags  [16];
  logic [31:0] lines [16];
  logic [31:0] hold_data;

  logic        is_store;
  logic        is_load;
  logic [3:0]  index;
  logic [25:0] tag;
  logic        hit;
  logic [3:0]  fill_index;
  logic [25:0] fill_tag;
  logic        fill_hit;
  logic [31:0] load_data;
  logic        cw_en;

  // A load+store combination behaves as a store.
  assign is_store   = ac_is_store;
  assign is_load    = ac_is_load & ~ac_is_store;
  assign index      = ALU_result[5:2];
  assign tag        = ALU_result[31:6];
  assign hit        = valid[index] && (tags[index] == tag);
  assign fill_index = mem_addr[5:2];
  assign fill_tag   = mem_addr[31:6];
  assign fill_hit   = valid[fill_index] && (tags[fill_index] == fill_tag);
  assign cw_en      = ~dcache_stall & ~icache_stall;

  always_comb begin
    dcache_stall = 1'b0;
    load_data    = lines[index];
    case (state)
      IDLE:      dcache_stall = is_store | (is_load & ~hit);
      LOAD_MISS: begin
        dcache_stall = ~mem_ack;
        load_data    = mem_rdata;
      end
      STORE_WR:  dcache_stall = ~mem_ack;
      HOLD:      load_data = hold_data;
      default:   dcache_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      hold_data    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cw_pc        <= '0;
      cw_is_wb     <= 1'b0;
      cw_write_sel <= '0;
      cw_result    <= '0;
    end else begin
      if (cw_en) begin
        cw_pc        <= ac_pc;
        cw_write_sel <= ac_write_sel;
        cw_is_wb     <= ac_is_wb;
        cw_result    <= is_load ? load_data : ALU_result;
      end
      case (state)
        IDLE: begin
          if (is_store) begin
            state     <= STORE_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ALU_result[31:2], 2'b00};
            mem_wdata <= ac_data2;
          end else if (is_load && !hit) begin
            state    <= LOAD_MISS;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {ALU_result[31:2], 2'b00};
          end
        end
        LOAD_MISS: begin
          if (mem_ack) begin
            mem_req            <= 1'b0;
            valid[fill_index]  <= 1'b1;
            hold_data          <= mem_rdata;
            state              <= icache_stall ? HOLD : IDLE;
          end
        end
        STORE_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= icache_stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!icache_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage is not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clock) begin
    if (state == LOAD_MISS && mem_ack) begin
      tags[fill_index]  <= fill_tag;
      lines[fill_index] <= mem_rdata;
    end else if (state == STORE_WR && mem_ack && fill_hit) begin
      lines[fill_index] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_stage.sv
// Bench for dcache_stage: a transaction-level cache/memory model drives expectations
// that a per-cycle compare process checks against the DUT.
module tb_dcache_stage;

  logic        clock, reset, icache_stall;
  logic [31:0] ac_pc, ALU_result, ac_data2;
  logic [4:0]  ac_write_sel;
  logic        ac_is_load, ac_is_store, ac_is_wb;
  logic        dcache_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] cw_pc, cw_result;
  logic        cw_is_wb;
  logic [4:0]  cw_write_sel;

  dcache_stage dut (
    .clock(clock), .reset(reset), .icache_stall(icache_stall),
    .ac_pc(ac_pc), .ac_write_sel(ac_write_sel), .ac_is_load(ac_is_load),
    .ac_is_store(ac_is_store), .ac_is_wb(ac_is_wb), .ALU_result(ALU_result),
    .ac_data2(ac_data2), .dcache_stall(dcache_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .cw_pc(cw_pc),
    .cw_is_wb(cw_is_wb), .cw_write_sel(cw_write_sel), .cw_result(cw_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assertions = 0;
  int failures   = 0;

  // Model: cache contents, backing memory, and what the DUT outputs must currently be.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem_model [logic [31:0]];

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_cw_wb;
  logic [31:0] exp_addr, exp_wdata, exp_cw_pc, exp_cw_result;
  logic [4:0]  exp_cw_sel;
  int          exp_writes = 0;
  int          writes_seen = 0;
  logic        req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("dcache_stall", {31'b0, dcache_stall}, {31'b0, exp_stall});
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (exp_req) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      check("cw_pc", cw_pc, exp_cw_pc);
      check("cw_write_sel", {27'b0, cw_write_sel}, {27'b0, exp_cw_sel});
      check("cw_is_wb", {31'b0, cw_is_wb}, {31'b0, exp_cw_wb});
      check("cw_result", cw_result, exp_cw_result);
    end
  end

  always @(posedge clock) begin
    if (mem_req && !req_prev && mem_we) writes_seen++;
    req_prev = mem_req;
  end

  task automatic next_cycle();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wdata = '0;
    exp_cw_pc = '0; exp_cw_sel = '0; exp_cw_wb = 1'b0; exp_cw_result = '0;
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] pc,
                               input logic [4:0] sel, input logic wb,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int ack_cycles, input int hold_cycles);
    logic        is_load, is_store, hit;
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [31:0] word, result;
    is_store = st;
    is_load  = ld & ~st;
    idx  = addr[5:2];
    tg   = addr[31:6];
    word = {addr[31:2], 2'b00};
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    ac_pc = pc; ac_write_sel = sel; ac_is_load = ld; ac_is_store = st; ac_is_wb = wb;
    ALU_result = addr; ac_data2 = wdata; icache_stall = 1'b0; mem_ack = 1'b0;
    result = addr;
    if (is_load && hit) result = m_data[idx];
    exp_stall = is_store | (is_load & ~hit);
    if (exp_stall) begin
      next_cycle();
      exp_req = 1'b1; exp_we = is_store; exp_addr = word; exp_wdata = wdata;
      for (int k = 1; k < ack_cycles; k++) begin
        mem_rdata = $urandom;
        next_cycle();
      end
      mem_ack = 1'b1;
      exp_stall = 1'b0;
      icache_stall = (hold_cycles > 0);
      if (is_load) begin
        mem_rdata = mem_model.exists(word) ? mem_model[word] : 32'h0;
        result = mem_rdata;
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = mem_rdata;
      end else begin
        mem_rdata = $urandom;
        mem_model[word] = wdata;
        exp_writes++;
        if (hit) m_data[idx] = wdata;
      end
      next_cycle();
      mem_ack = 1'b0;
      exp_req = 1'b0;
      // Extra HOLD cycles; a stray ack here must be ignored.
      for (int h = 1; h < hold_cycles; h++) begin
        mem_ack = (h == 1);
        mem_rdata = $urandom;
        next_cycle();
      end
      mem_ack = 1'b0;
      if (hold_cycles > 0) begin
        icache_stall = 1'b0;
        next_cycle();
      end
    end else begin
      next_cycle();
    end
    exp_cw_pc = pc; exp_cw_sel = sel; exp_cw_wb = wb; exp_cw_result = result;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    reset = 1'b0; icache_stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ac_pc = '0; ac_write_sel = '0; ac_is_load = 1'b0; ac_is_store = 1'b0;
    ac_is_wb = 1'b0; ALU_result = '0; ac_data2 = '0;
    mem_model[32'h100] = 32'hDEADBEEF;
    mem_model[32'h140] = 32'hCAFEF00D;
    mem_model[32'h180] = 32'h11223344;
    mem_model[32'h200] = 32'h600DCAFE;
    clear_model();
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("reset cw_pc", cw_pc, 32'h0);
    checkOutput("reset cw_result", cw_result, 32'h0);
    checkOutput("reset cw_is_wb", {31'b0, cw_is_wb}, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    applyStimulus(1, 0, 32'h1000, 5'd5, 1, 32'h100, 32'h0, 3, 0);
    checkOutput("first load result", cw_result, 32'hDEADBEEF);
    checkOutput("first load wb", {31'b0, cw_is_wb}, 32'h1);
    applyStimulus(1, 0, 32'h1004, 5'd6, 1, 32'h100, 32'h0, 1, 0);
    checkOutput("load hit result", cw_result, 32'hDEADBEEF);
    applyStimulus(0, 1, 32'h1008, 5'd0, 0, 32'h100, 32'h12345678, 2, 0);
    applyStimulus(1, 0, 32'h100C, 5'd7, 1, 32'h100, 32'h0, 1, 0);
    checkOutput("store-hit reload", cw_result, 32'h12345678);
    applyStimulus(1, 0, 32'h1010, 5'd8, 1, 32'h140, 32'h0, 1, 0);
    checkOutput("replace line", cw_result, 32'hCAFEF00D);
    applyStimulus(1, 0, 32'h1014, 5'd9, 1, 32'h100, 32'h0, 2, 0);
    checkOutput("evicted reload", cw_result, 32'h12345678);
    applyStimulus(0, 1, 32'h1018, 5'd0, 0, 32'h104, 32'hA5A5A5A5, 2, 3);
    applyStimulus(1, 0, 32'h101C, 5'd10, 1, 32'h104, 32'h0, 1, 0);
    checkOutput("store-miss reload", cw_result, 32'hA5A5A5A5);
    applyStimulus(0, 0, 32'h1020, 5'd11, 1, 32'h55, 32'h0, 1, 0);
    checkOutput("alu op", cw_result, 32'h55);
    applyStimulus(1, 1, 32'h1024, 5'd12, 0, 32'h140, 32'h0BADF00D, 1, 0);
    applyStimulus(1, 0, 32'h1028, 5'd13, 1, 32'h140, 32'h0, 2, 0);
    checkOutput("ld+st as store", cw_result, 32'h0BADF00D);
    applyStimulus(1, 0, 32'h102C, 5'd14, 1, 32'h200, 32'h0, 2, 2);
    checkOutput("held load", cw_result, 32'h600DCAFE);

    // Reset in the middle of a load miss to a fresh line.
    ac_pc = 32'h2000; ac_write_sel = 5'd3; ac_is_load = 1'b1; ac_is_store = 1'b0;
    ac_is_wb = 1'b1; ALU_result = 32'h180;
    exp_stall = 1'b1;
    next_cycle();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h180;
    @(negedge clock);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset drops mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset cw_pc mid", cw_pc, 32'h0);
    checkOutput("reset cw_sel mid", {27'b0, cw_write_sel}, 32'h0);
    checkOutput("reset cw_wb mid", {31'b0, cw_is_wb}, 32'h0);
    checkOutput("reset cw_result mid", cw_result, 32'h0);
    clear_model();
    ac_is_load = 1'b0; ac_is_wb = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    applyStimulus(1, 0, 32'h2004, 5'd4, 1, 32'h180, 32'h0, 2, 0);
    checkOutput("reload after reset", cw_result, 32'h11223344);
    applyStimulus(1, 0, 32'h2008, 5'd4, 1, 32'h200, 32'h0, 1, 0);
    checkOutput("old line invalid", cw_result, 32'h600DCAFE);

    ac_is_load = 1'b0; ac_is_store = 1'b0;
    next_cycle();
    chk_en = 1'b0;
    checkOutput("write count", writes_seen, exp_writes);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dcache_stage.md
DCACHE_STAGE -- requirements
Module: dcache_stage

Interface
REQ-001 SHALL have the ports below (clock and reset first). One clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  async, active-high
- icache_stall  in  1  fetch stall; freezes cw_* register
- ac_pc  in  32  instruction PC from execute stage
- ac_write_sel  in  5  destination register
- ac_is_load, ac_is_store, ac_is_wb  in  1 each  instruction class
- ALU_result  in  32  ALU value; byte address for load/store
- ac_data2  in  32  store data
- dcache_stall  out  1  combinational pipeline stall
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word address {ALU_result[31:2],2'b00}
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- cw_pc  out  32  registered PC to writeback
- cw_is_wb  out  1  registered writeback enable, also bypass to execute
- cw_write_sel  out  5  registered destination
- cw_result  out  32  registered result, also bypass to execute

Function
REQ-002 Cache SHALL be direct-mapped: 16 lines, one 32-bit word per line, valid bit per line; index=ALU_result[5:2], tag=ALU_result[31:6]; ALU_result[1:0] ignored.
REQ-003 Policy SHALL be write-through, no-write-allocate: a store hit updates the line, a store miss leaves the cache unchanged, every store writes memory.
REQ-004 FSM states SHALL be IDLE, LOAD_MISS, STORE_WR, HOLD.
REQ-005 IDLE, load hit: dcache_stall=0; cw_result captures line data at the next enabled edge.
REQ-006 IDLE, load miss: dcache_stall=1 in the same cycle; next state LOAD_MISS.
REQ-007 IDLE, store (hit or miss): dcache_stall=1 in the same cycle; next state STORE_WR.
REQ-008 ac_is_load and ac_is_store both set SHALL be treated as a store.
REQ-009 LOAD_MISS/STORE_WR SHALL assert mem_req with mem_we=0/1 and hold mem_addr and mem_wdata stable until mem_ack.
REQ-010 In LOAD_MISS/STORE_WR, dcache_stall SHALL equal !mem_ack.
REQ-011 On mem_ack in LOAD_MISS: fill line (valid=1, tag, mem_rdata); capture mem_rdata into an internal hold register.
REQ-012 On mem_ack in STORE_WR: update the line only on a tag hit.
REQ-013 On mem_ack: if icache_stall=0, next state IDLE (cw_* advances the same edge); otherwise next state HOLD.
REQ-014 HOLD SHALL keep dcache_stall=0 and mem_req=0, source a load result from the hold register, and return to IDLE on the first edge with icache_stall=0.
REQ-015 Each store SHALL cause exactly one memory write; each load miss exactly one memory read.
REQ-016 cw_* SHALL update only on edges where dcache_stall=0 and icache_stall=0.
REQ-017 cw_* update values: cw_pc<=ac_pc, cw_write_sel<=ac_write_sel, cw_is_wb<=ac_is_wb, cw_result<=load data for loads, otherwise ALU_result.
REQ-018 Non-memory instructions and bubbles (all ac_is_* = 0) SHALL never stall and never assert mem_req.
REQ-019 mem_ack SHALL be ignored in IDLE and HOLD.
REQ-020 Hit/miss lookup SHALL complete in one cycle; load-hit latency to cw_result is one edge.

Reset
REQ-021 Reset SHALL force: state=IDLE; all valid bits=0; mem_req=0, mem_we=0; cw_pc, cw_write_sel, cw_is_wb, cw_result=0; hold register=0.
REQ-022 Reset mid-transaction SHALL drop mem_req immediately, abandon the transaction, and fill no line.
REQ-023 Line data and tags need no reset.

Verification
REQ-024 Benches SHALL cover:
- Reset, then load 0x100; ack 3 cycles later with rdata 0xDEADBEEF -> stall asserts in the load cycle; mem_req=1, we=0, addr=0x100; stall drops in the ack cycle; next edge cw_result=0xDEADBEEF, cw_is_wb=1.
- Load 0x100 again -> no stall, no mem_req; cw_result=0xDEADBEEF one edge later.
- Store 0x12345678 to 0x100 -> one write: we=1, addr=0x100, wdata=0x12345678; then load 0x100 hits returning 0x12345678.
- Load 0x140 (index 0, new tag) -> miss replaces line; following load 0x100 misses again.
- icache_stall=1 at store ack -> HOLD, single write only; cw_* updates on the edge icache_stall drops.
- Non-memory op, ALU_result=0x55 -> no stall; cw_result=0x55 next edge.
- Reset during LOAD_MISS -> mem_req=0 at once; cw_* all 0; reload of the same address misses.
